pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Elastic pipeline stage register for the RV pipeline.
//  - Generalises the plain enable-gated stage register with a valid/ready handshake.
//  - Adds an optional 2-entry skid buffer, synchronous flush (bubble insertion) and a
//    configurable bubble value on idle.
//  - Adds a saturating back-pressure counter.
//  - Sits between any two pipeline stages, e.g. IF/ID with BUBBLE = RV NOP.
// PARAMETERS
//  N       32           payload width in bits; no functional limit, must be >= 1
//  SKID    1            1 = 2-entry skid buffer, in_ready registered;
//                       0 = single entry, in_ready combinational
//  BUBBLE  '0 (N bits)  value driven on out_data whenever out_valid = 0
//  CNT_W   16           width of stall_cnt
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  flush      in   1      synchronous flush; discards all held and incoming data
//  clr_stats  in   1      synchronous clear of stall_cnt
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      stage can accept a payload this cycle
//  in_data    in   N      upstream payload
//  out_valid  out  1      downstream payload valid
//  out_ready  in   1      downstream accepts the payload this cycle
//  out_data   out  N      downstream payload; equals BUBBLE when out_valid = 0
//  stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset (async) values
//   - out_valid = 0, out_data = BUBBLE, stall_cnt = 0, state = EMPTY.
//   - in_ready is forced 0 while rst is high; it is 1 from the first cycle after release.
//  Handshake rules
//   - Transfer in  = in_valid & in_ready.  Transfer out = out_valid & out_ready.
//   - in_data is sampled on transfer-in edges only.
//   - out_data/out_valid are held stable until transfer-out (AXI-style).
//   - Latency: 1 cycle from transfer-in to out_valid when the stage is empty.
//   - Throughput: 1 per cycle under no back-pressure. Order is strictly FIFO.
//  State machine (SKID = 1)
//   States:
//   - EMPTY: main and skid invalid; in_ready = 1.
//   - ONE:   main valid; in_ready = 1.
//   - TWO:   main and skid valid; in_ready = 0.
//   Transitions:
//   - EMPTY -> ONE:   on transfer-in.
//   - ONE   -> EMPTY: out only.
//   - ONE   -> ONE:   in & out (main reloads), or no transfers.
//   - ONE   -> TWO:   in & !out_ready (payload goes to skid).
//   - TWO   -> ONE:   on out (skid moves to main).
//   in_ready is a function of registered state only; no in_ready <- out_ready comb path.
//  SKID = 0
//   - Single main entry; in_ready = !out_valid | out_ready (combinational).
//   - State TWO is never entered.
//  Flush
//   - Highest priority after rst.
//   - Next state = EMPTY; both entries invalidated.
//   - A transfer-in in the same cycle is discarded.
//   - out_valid = 0 and out_data = BUBBLE from the next cycle.
//   - stall_cnt is unaffected.
//  stall_cnt
//   - +1 on each cycle with out_valid & !out_ready; holds at 2^CNT_W-1.
//   - clr_stats wins over increment (result 0).
//  Boundaries
//   - in_valid in TWO: not accepted; data must be held by upstream.
//   - Reset asserted mid-transfer: all data lost; no partial state survives.
//   - flush & clr_stats same cycle: both take effect.
// STRUCTURE
//  pipe_pkg (shared):
//   - typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_e;
//   - localparam logic [31:0] RV_NOP = 32'h0000_0013 (BUBBLE for instruction stages).
//  Sub-module sat_counter #(W) (clk, rst, clr, inc, count): instantiated once for stall_cnt.
//  Skid/main registers and FSM are inline.
// TESTING
//  1. Reset with SKID=1, N=32, BUBBLE=RV_NOP
//     -> out_valid=0, out_data=0x00000013, in_ready=0 during rst, 1 on the first cycle after.
//  2. Stream 0x1..0x8, out_ready=1 constantly
//     -> out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
//  3. Push 0xA, 0xB with out_ready=0
//     -> state TWO, in_ready=0, out_data holds 0xA;
//     -> then out_ready=1 gives 0xA, then 0xB, and in_ready returns to 1 after the first pop.
//  4. Flush while TWO with in_valid=1, in_data=0xC
//     -> next cycle out_valid=0, out_data=BUBBLE, 0xC never appears, in_ready=1.
//  5. CNT_W=4, out_valid=1, out_ready=0 for 20 cycles
//     -> stall_cnt saturates at 15; clr_stats pulse gives 0 the next cycle.
//  6. SKID=0: out_valid=1, out_ready=1, in_valid=1, in_data=0xD same cycle
//     -> in_ready=1 combinationally; 0xD on out_data next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for elastic pipeline stages.
package pipe_pkg;

    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_e;

    // Canonical RV NOP (addi x0, x0, 0), used as the bubble for instruction stages.
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer,
// synchronous flush, bubble value on idle and a saturating stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int           N      = 32,
    parameter int           SKID   = 1,
    parameter logic [N-1:0] BUBBLE = '0,
    parameter int           CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             clr_stats,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_e r_state;
    pipe_state_e w_state_nxt;
    logic        r_alive;
    logic [N-1:0] r_main;
    logic [N-1:0] r_skid;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_ld_main;
    logic        w_ld_skid;
    logic        w_mv_skid;

    assign out_valid = (r_state != PS_EMPTY);
    assign out_data  = out_valid ? r_main : BUBBLE;

    // r_alive holds in_ready low through reset and releases it on the first edge after.
    assign in_ready = (SKID != 0) ? (r_alive && (r_state != PS_TWO))
                                  : (r_alive && (!out_valid || out_ready));

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ld_main   = 1'b0;
        w_ld_skid   = 1'b0;
        w_mv_skid   = 1'b0;
        if (flush) begin
            w_state_nxt = PS_EMPTY;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = PS_ONE;
                        w_ld_main   = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_ld_main = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = PS_EMPTY;
                    end else if (w_in_xfer && (SKID != 0)) begin
                        w_state_nxt = PS_TWO;
                        w_ld_skid   = 1'b1;
                    end
                end
                PS_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt = PS_ONE;
                        w_mv_skid   = 1'b1;
                    end
                end
                default: w_state_nxt = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PS_EMPTY;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    // Payload registers carry no reset; validity lives entirely in r_state.
    always_ff @(posedge clk) begin
        if (w_ld_main) begin
            r_main <= in_data;
        end else if (w_mv_skid) begin
            r_main <= r_skid;
        end
        if (w_ld_skid) begin
            r_skid <= in_data;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_stats),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid build (CNT_W=4) and single-entry build.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    logic clk;
    logic rst;

    logic        flush1, clr1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_data1, out_data1;
    logic [3:0]  stall1;

    logic        flush0, clr0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_data0, out_data0;
    logic [15:0] stall0;

    int errors;
    int checks;

    pipe_stage_elastic #(.N(32), .SKID(1), .BUBBLE(RV_NOP), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .clr_stats(clr1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .stall_cnt(stall1)
    );

    pipe_stage_elastic #(.N(32), .SKID(0), .BUBBLE(RV_NOP), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .clr_stats(clr0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .stall_cnt(stall0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL rst_in_ready1 got=%b exp=0", in_ready1); end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL rst_in_ready0 got=%b exp=0", in_ready0); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid1); end
        checks++; if (out_data1 !== 32'h13) begin errors++; $display("FAIL rst_out_data got=%h exp=00000013", out_data1); end
        checks++; if (stall1 !== 4'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall1); end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready1 got=%b exp=1", in_ready1); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready0 got=%b exp=1", in_ready0); end
    endtask

    task automatic test_stream;
        out_ready1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_data1  = 32'(k + 1);
            #1;
            checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, in_ready1); end
            if (k >= 1) begin
                checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== 32'(k)) begin
                    errors++; $display("FAIL stream_out k=%0d got=%b/%h exp=1/%h", k, out_valid1, out_data1, 32'(k));
                end
            end
        end
        @(negedge clk); in_valid1 = 1'b0; #1;
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'h8) begin errors++; $display("FAIL stream_last got=%b/%h exp=1/00000008", out_valid1, out_data1); end
        @(negedge clk); #1;
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h13) begin errors++; $display("FAIL stream_idle got=%b/%h exp=0/00000013", out_valid1, out_data1); end
    endtask

    task automatic test_skid;
        @(negedge clk); in_valid1 = 1'b1; in_data1 = 32'hA; out_ready1 = 1'b0; #1;
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL skid_rdy_a got=%b exp=1", in_ready1); end
        @(negedge clk); in_data1 = 32'hB; #1;
        checks++; if (in_ready1 !== 1'b1 || out_data1 !== 32'hA) begin errors++; $display("FAIL skid_b got=%b/%h exp=1/0000000a", in_ready1, out_data1); end
        @(negedge clk); in_valid1 = 1'b0; #1;
        checks++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_data1 !== 32'hA) begin
            errors++; $display("FAIL skid_two got=%b/%b/%h exp=0/1/0000000a", in_ready1, out_valid1, out_data1);
        end
        @(negedge clk); out_ready1 = 1'b1; #1;
        checks++; if (in_ready1 !== 1'b0 || out_data1 !== 32'hA) begin errors++; $display("FAIL skid_hold got=%b/%h exp=0/0000000a", in_ready1, out_data1); end
        @(negedge clk); #1;
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b1 || out_data1 !== 32'hB) begin
            errors++; $display("FAIL skid_pop1 got=%b/%b/%h exp=1/1/0000000b", in_ready1, out_valid1, out_data1);
        end
        @(negedge clk); #1;
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL skid_pop2 got=%b exp=0", out_valid1); end
    endtask

    task automatic test_flush;
        @(negedge clk); in_valid1 = 1'b1; in_data1 = 32'h21; out_ready1 = 1'b0;
        @(negedge clk); in_data1 = 32'h22;
        @(negedge clk); in_data1 = 32'hC; flush1 = 1'b1; clr1 = 1'b1; #1;
        checks++; if (in_ready1 !== 1'b0 || stall1 === 4'd0) begin errors++; $display("FAIL flush_pre got=%b/%0d exp=0/nonzero", in_ready1, stall1); end
        @(negedge clk); flush1 = 1'b0; clr1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; #1;
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h13 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL flush_after got=%b/%h/%b exp=0/00000013/1", out_valid1, out_data1, in_ready1);
        end
        checks++; if (stall1 !== 4'd0) begin errors++; $display("FAIL flush_clr got=%0d exp=0", stall1); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h13) begin
                errors++; $display("FAIL flush_quiet i=%0d got=%b/%h exp=0/00000013", i, out_valid1, out_data1);
            end
        end
    endtask

    task automatic test_stall_cnt;
        logic [3:0] exp_cnt;
        @(negedge clk); in_valid1 = 1'b1; in_data1 = 32'h5; out_ready1 = 1'b0;
        @(negedge clk); in_valid1 = 1'b0; #1;
        checks++; if (stall1 !== 4'd0) begin errors++; $display("FAIL stall_start got=%0d exp=0", stall1); end
        for (int i = 1; i < 20; i++) begin
            @(negedge clk); #1;
            exp_cnt = (i < 15) ? 4'(i) : 4'd15;
            if (i == 3 || i == 15 || i == 19) begin
                checks++; if (stall1 !== exp_cnt) begin errors++; $display("FAIL stall_i%0d got=%0d exp=%0d", i, stall1, exp_cnt); end
            end
        end
        @(negedge clk); clr1 = 1'b1;
        @(negedge clk); clr1 = 1'b0; #1;
        checks++; if (stall1 !== 4'd0) begin errors++; $display("FAIL stall_clr got=%0d exp=0", stall1); end
        @(negedge clk); #1;
        checks++; if (stall1 !== 4'd1) begin errors++; $display("FAIL stall_resume got=%0d exp=1", stall1); end
        out_ready1 = 1'b1;
        @(negedge clk); #1;
        checks++; if (out_valid1 !== 1'b0 || stall1 !== 4'd1) begin errors++; $display("FAIL stall_drain got=%b/%0d exp=0/1", out_valid1, stall1); end
    endtask

    task automatic test_no_skid;
        @(negedge clk); in_valid0 = 1'b1; in_data0 = 32'h30; out_ready0 = 1'b0; #1;
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL ns_rdy_empty got=%b exp=1", in_ready0); end
        @(negedge clk); in_valid0 = 1'b0; #1;
        checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'h30 || in_ready0 !== 1'b0) begin
            errors++; $display("FAIL ns_full got=%b/%h/%b exp=1/00000030/0", out_valid0, out_data0, in_ready0);
        end
        out_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = 32'hD; #1;
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL ns_comb_rdy got=%b exp=1", in_ready0); end
        @(negedge clk); in_valid0 = 1'b0; #1;
        checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'hD) begin errors++; $display("FAIL ns_d got=%b/%h exp=1/0000000d", out_valid0, out_data0); end
        @(negedge clk); #1;
        checks++; if (out_valid0 !== 1'b0 || out_data0 !== 32'h13) begin errors++; $display("FAIL ns_idle got=%b/%h exp=0/00000013", out_valid0, out_data0); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        flush1 = 1'b0; clr1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        flush0 = 1'b0; clr0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_stall_cnt();
        test_no_skid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
